// File: rtl/decim_avg.sv
// Block-average decimator: sums 2**LOG2_N valid samples, emits the floor mean
// into a small in-order output FIFO with a valid/ready handshake.
module decim_avg #(
  parameter int DATA_W     = 32,
  parameter int LOG2_N     = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x,
  input  logic              in_valid,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              overflow
);

  localparam int AW = DATA_W + LOG2_N;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LOG2_N-1:0] LAST = '1;

  logic [AW-1:0]     acc_q, acc_d, sum;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] y_q, y_d, result, head_d;
  logic              ovf_q, ovf_d;
  logic              blk_end, full, pop, push_ok, drop;

  function automatic logic [DATA_W-1:0] floor_mean(input logic [AW-1:0] s);
    return DATA_W'(s >> LOG2_N);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Accumulate stage: the first sample of a block overwrites the stale sum
  always_comb begin
    sum     = ((cnt_q == '0) ? '0 : acc_q) + AW'(x);
    blk_end = in_valid && (cnt_q == LAST);
    result  = floor_mean(sum);
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (in_valid) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // FIFO stage: a pop on a full FIFO frees the slot for a same-edge push
  always_comb begin
    full    = (count_q == CW'(FIFO_DEPTH));
    pop     = (count_q != '0) && y_ready;
    push_ok = blk_end && (!full || pop);
    drop    = blk_end && full && !pop;
    wr_d    = push_ok ? ptr_inc(wr_q) : wr_q;
    rd_d    = pop ? ptr_inc(rd_q) : rd_q;
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    head_d  = (push_ok && (rd_d == wr_q)) ? result : mem_q[rd_d];
    y_d     = (count_d != '0) ? head_d : y_q;
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= result;
  end

  assign y        = y_q;
  assign y_valid  = (count_q != '0);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_decim_avg.sv
// Directed self-checking bench for decim_avg with DATA_W=32, N=4, FIFO_DEPTH=2.
module tb_decim_avg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] x;
  logic        in_valid;
  logic [31:0] y;
  logic        y_valid;
  logic        y_ready;
  logic        overflow;
  int          n_run  = 0;
  int          n_fail = 0;

  decim_avg #(.DATA_W(32), .LOG2_N(2), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [31:0] v);
    in_valid = 1'b1;
    x = v;
    tick();
  endtask

  task automatic block(input logic [31:0] v);
    for (int i = 0; i < 4; i++) sample(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; x = '0; in_valid = 1'b0; y_ready = 1'b0;
    #2;
    chk("rst_y", y, 32'h0);
    chk("rst_yv", {31'b0, y_valid}, 32'h0);
    chk("rst_ovf", {31'b0, overflow}, 32'h0);
    do_reset();

    // 1: basic mean
    y_ready = 1'b1;
    sample(1); sample(2); sample(3);
    chk("t1_pre_yv", {31'b0, y_valid}, 32'h0);
    sample(4);
    chk("t1_y", y, 32'd2);
    chk("t1_yv", {31'b0, y_valid}, 32'h1);
    chk("t1_ovf", {31'b0, overflow}, 32'h0);
    in_valid = 1'b0;
    tick();
    chk("t1_pop_yv", {31'b0, y_valid}, 32'h0);
    chk("t1_hold_y", y, 32'd2);

    // 2: wide accumulator
    block(32'hFFFF_FFFF);
    chk("t2_y", y, 32'hFFFF_FFFF);
    chk("t2_yv", {31'b0, y_valid}, 32'h1);
    in_valid = 1'b0;
    tick();

    // 3: gaps do not break a block
    sample(4);  in_valid = 1'b0; tick();
    sample(8);  in_valid = 1'b0; tick();
    sample(12); in_valid = 1'b0; tick();
    chk("t3_gap_yv", {31'b0, y_valid}, 32'h0);
    sample(16);
    chk("t3_y", y, 32'd10);
    chk("t3_yv", {31'b0, y_valid}, 32'h1);
    in_valid = 1'b0;
    tick();

    // 4: overflow with stalled consumer
    y_ready = 1'b0;
    block(4);
    chk("t4_y_first", y, 32'd4);
    block(8);
    chk("t4_ovf_pre", {31'b0, overflow}, 32'h0);
    block(12);
    chk("t4_ovf", {31'b0, overflow}, 32'h1);
    chk("t4_head", y, 32'd4);
    in_valid = 1'b0;
    y_ready = 1'b1;
    tick();
    chk("t4_pop1_y", y, 32'd8);
    chk("t4_pop1_yv", {31'b0, y_valid}, 32'h1);
    tick();
    chk("t4_pop2_yv", {31'b0, y_valid}, 32'h0);
    chk("t4_pop2_y", y, 32'd8);
    chk("t4_ovf_sticky", {31'b0, overflow}, 32'h1);

    // 5: push and pop on the same edge while full
    y_ready = 1'b0;
    do_reset();
    chk("t5_rst_ovf", {31'b0, overflow}, 32'h0);
    block(20);
    block(24);
    sample(28); sample(28); sample(28);
    y_ready = 1'b1;
    sample(28);
    chk("t5_ovf", {31'b0, overflow}, 32'h0);
    chk("t5_y1", y, 32'd24);
    in_valid = 1'b0;
    tick();
    chk("t5_y2", y, 32'd28);
    chk("t5_y2v", {31'b0, y_valid}, 32'h1);
    tick();
    chk("t5_empty", {31'b0, y_valid}, 32'h0);

    // 6: async reset mid-block discards partial sum
    y_ready = 1'b0;
    block(8); block(8); block(8);
    chk("t6_pre_ovf", {31'b0, overflow}, 32'h1);
    chk("t6_pre_y", y, 32'd8);
    sample(1); sample(2);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_y", y, 32'h0);
    chk("t6_rst_yv", {31'b0, y_valid}, 32'h0);
    chk("t6_rst_ovf", {31'b0, overflow}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    y_ready = 1'b1;
    sample(1); sample(2); sample(3);
    chk("t6_partial_yv", {31'b0, y_valid}, 32'h0);
    sample(4);
    chk("t6_y", y, 32'd2);
    chk("t6_yv", {31'b0, y_valid}, 32'h1);
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
